// File: rtl/icg_enable_sequencer.sv
// Clock-gate enable sequencer: per-domain REQ/ACK handshake, one round-robin
// wake-up at a time, and a hold-off window before each gate closes.
module icg_enable_sequencer #(
    parameter int N_DOM       = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_DOM-1:0] req_i,
    input  logic             force_on_i,
    input  logic             scan_en_i,
    output logic [N_DOM-1:0] e_o,
    output logic             te_o,
    output logic [N_DOM-1:0] ack_o,
    output logic             busy_o
);

    localparam int PTR_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_DOM  = PTR_W'(N_DOM - 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_WAKING = 2'd1,
        S_ON     = 2'd2,
        S_HOLD   = 2'd3
    } dom_state_e;

    dom_state_e       state_q [N_DOM];
    dom_state_e       state_d [N_DOM];
    logic [CNT_W-1:0] cnt_q   [N_DOM];
    logic [CNT_W-1:0] cnt_d   [N_DOM];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_DOM-1:0] en_q, en_d;
    logic [N_DOM-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;

    logic [N_DOM-1:0] cand_s;
    logic             grant_s;
    logic [PTR_W-1:0] grant_idx_s;

    // Wake candidates: idle domains that are asking for their clock.
    always_comb begin
        cand_s = {N_DOM{1'b0}};
        for (int i = 0; i < N_DOM; i++) begin
            cand_s[i] = (state_q[i] == S_OFF) & req_i[i];
        end
    end

    // Round-robin pick, blocked while any domain is still waking.
    always_comb begin
        int idx;
        idx         = 0;
        grant_s     = 1'b0;
        grant_idx_s = {PTR_W{1'b0}};
        if (!busy_q) begin
            for (int k = 0; k < N_DOM; k++) begin
                idx = (int'(ptr_q) + k) % N_DOM;
                if (!grant_s && cand_s[idx]) begin
                    grant_s     = 1'b1;
                    grant_idx_s = PTR_W'(idx);
                end else begin
                    grant_s = grant_s;
                end
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    // Pointer moves past the winner only when a grant happens.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_s) begin
            if (grant_idx_s == LAST_DOM) begin
                ptr_d = {PTR_W{1'b0}};
            end else begin
                ptr_d = grant_idx_s + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Per-domain next state plus the registered output images derived from it.
    always_comb begin
        busy_d = 1'b0;
        en_d   = {N_DOM{1'b0}};
        ack_d  = {N_DOM{1'b0}};
        for (int i = 0; i < N_DOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_OFF: begin
                    if (grant_s && (grant_idx_s == PTR_W'(i))) begin
                        state_d[i] = S_WAKING;
                        cnt_d[i]   = WAKE_LOAD;
                    end else begin
                        state_d[i] = S_OFF;
                    end
                end
                S_WAKING: begin
                    // A wake-up always runs to completion; REQ only picks the exit.
                    if (cnt_q[i] == {CNT_W{1'b0}}) begin
                        if (req_i[i]) begin
                            state_d[i] = S_ON;
                        end else begin
                            state_d[i] = S_HOLD;
                            cnt_d[i]   = HOLD_LOAD;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (!req_i[i]) begin
                        state_d[i] = S_HOLD;
                        cnt_d[i]   = HOLD_LOAD;
                    end else begin
                        state_d[i] = S_ON;
                    end
                end
                S_HOLD: begin
                    if (req_i[i]) begin
                        state_d[i] = S_ON;
                    end else if (cnt_q[i] == {CNT_W{1'b0}}) begin
                        state_d[i] = S_OFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = S_OFF;
                    cnt_d[i]   = {CNT_W{1'b0}};
                end
            endcase
            en_d[i]  = (state_d[i] != S_OFF);
            ack_d[i] = (state_d[i] == S_ON);
            busy_d   = busy_d | (state_d[i] == S_WAKING);
        end
    end

    // State, counters, pointer and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_DOM; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= {CNT_W{1'b0}};
            end
            ptr_q  <= {PTR_W{1'b0}};
            en_q   <= {N_DOM{1'b0}};
            ack_q  <= {N_DOM{1'b0}};
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_DOM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ptr_q  <= ptr_d;
            en_q   <= en_d;
            ack_q  <= ack_d;
            busy_q <= busy_d;
        end
    end

    // FORCE_ON only ORs into the pins, so releasing it never cuts a running clock.
    assign e_o    = en_q | {N_DOM{force_on_i}};
    assign te_o   = scan_en_i;
    assign ack_o  = ack_q;
    assign busy_o = busy_q;

endmodule
